conf_reg_responder: RTL

- DUT-side endpoint of the configuration interface. It accepts write transactions (c_addr, c_data, c_valid) under a c_ready handshake and commits them into a bank of configuration registers.
- Exposes the register contents and a per-write update strobe to downstream datapath logic.
- Tracks rejected writes (out-of-range address or bank locked) in a saturating error counter.

---
 rtl/conf_reg_responder_if.sv | 25 ++
 rtl/conf_reg_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/conf_reg_responder_if.sv
// Config write channel: valid/ready handshake carrying address and data.
// master drives c_valid/c_addr/c_data; slave drives c_ready.
interface conf_reg_responder_if #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 16
);
    logic                    c_valid;
    logic [C_ADDR_WIDTH-1:0] c_addr;
    logic [C_DATA_WIDTH-1:0] c_data;
    logic                    c_ready;

    modport master (
        output c_valid,
        output c_addr,
        output c_data,
        input  c_ready
    );

    modport slave (
        input  c_valid,
        input  c_addr,
        input  c_data,
        output c_ready
    );
endinterface

// File: rtl/conf_reg_responder.sv
// Config register responder: accepts writes on cif (slave), commits them
// into a register bank, tracks lock state and rejected writes.
// Ports: clk, rst_n (sync, active-low), cif (c_valid/c_addr/c_data/c_ready),
// cfg_regs (flattened bank), cfg_update/cfg_update_idx (write strobe),
// cfg_locked (CTRL bit0), err_cnt (saturating reject count).
// Macro CONF_SHADOW_EN: data writes land in a shadow bank that is copied
// to cfg_regs by a CTRL write with bit1 set.
module conf_reg_responder #(
    parameter int                    C_ADDR_WIDTH = 8,
    parameter int                    C_DATA_WIDTH = 16,
    parameter int                    NUM_REGS     = 8,
    parameter logic [C_ADDR_WIDTH-1:0] CTRL_ADDR  = 8'hFF,
    localparam int                   IDX_W        = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    conf_reg_responder_if.slave              cif,
    output logic [NUM_REGS*C_DATA_WIDTH-1:0] cfg_regs,
    output logic                             cfg_update,
    output logic [IDX_W-1:0]                 cfg_update_idx,
    output logic                             cfg_locked,
    output logic [7:0]                       err_cnt
);

    localparam logic [C_ADDR_WIDTH-1:0] NREG_A = C_ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_ACK
    } state_t;

    state_t state_q, state_d;

    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic                    pend_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    locked_q;
    logic [7:0]              err_q;
    logic [C_DATA_WIDTH-1:0] regs_q [NUM_REGS];
`ifdef CONF_SHADOW_EN
    logic [C_DATA_WIDTH-1:0] shadow_q [NUM_REGS];
`endif

    logic hit_data;
    logic hit_ctrl;

    // CTRL_ADDR >= NUM_REGS, so the two hits are mutually exclusive.
    // Full-width compares: no aliasing of upper address bits.
    assign hit_data = (addr_q < NREG_A) && !locked_q;
    assign hit_ctrl = (addr_q == CTRL_ADDR);

    // Ready comes straight from the state flop, never from c_valid.
    assign cif.c_ready    = (state_q == ST_IDLE);
    assign cfg_update     = (state_q == ST_ACK) && pend_q;
    assign cfg_update_idx = idx_q;
    assign cfg_locked     = locked_q;
    assign err_cnt        = err_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cif.c_valid) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            pend_q   <= 1'b0;
            idx_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
`ifdef CONF_SHADOW_EN
                shadow_q[i] <= '0;
`endif
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cif.c_valid) begin
                        addr_q <= cif.c_addr;
                        data_q <= cif.c_data;
                    end
                end
                ST_COMMIT: begin
                    unique case (1'b1)
                        hit_data: begin
`ifdef CONF_SHADOW_EN
                            shadow_q[addr_q[IDX_W-1:0]] <= data_q;
`else
                            regs_q[addr_q[IDX_W-1:0]] <= data_q;
                            pend_q <= 1'b1;
                            idx_q  <= addr_q[IDX_W-1:0];
`endif
                        end
                        hit_ctrl: begin
                            // New lock value governs the next transfer.
                            locked_q <= data_q[0];
`ifdef CONF_SHADOW_EN
                            if (data_q[1]) begin
                                regs_q <= shadow_q;
                                pend_q <= 1'b1;
                                idx_q  <= '0;
                            end
`endif
                        end
                        default: begin
                            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                        end
                    endcase
                end
                ST_ACK: pend_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
